// File: rtl/bmac_accumulator.sv
// rtl/bmac_accumulator.sv - saturating signed accumulator for XNOR-popcount partial products
// Sums vec_len signed chunks per dot product and hands the result downstream on valid/ready.
module bmac_accumulator #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy,
  output logic             sat_flag
);

  // One guard bit over the wider operand keeps the raw sum exact before clamping.
  localparam int SUM_W = ((ACC_W > IN_W) ? ACC_W : IN_W) + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               sat_flag_q, sat_flag_d;

  logic signed [SUM_W-1:0] acc_ext;
  logic signed [SUM_W-1:0] in_ext;
  logic signed [SUM_W-1:0] sum;
  logic [ACC_W-1:0]        acc_sat;
  logic                    sat_hit;

  always_comb begin
    acc_ext = SUM_W'($signed(acc_q));
    in_ext  = SUM_W'($signed(in_data));
    sum     = acc_ext + in_ext;
    sat_hit = 1'b0;
    acc_sat = sum[ACC_W-1:0];
    if (sum > ACC_MAX) begin
      acc_sat = ACC_MAX[ACC_W-1:0];
      sat_hit = 1'b1;
    end else if (sum < ACC_MIN) begin
      acc_sat = ACC_MIN[ACC_W-1:0];
      sat_hit = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sat_flag_d  = sat_flag_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d      = '0;
          sat_flag_d = 1'b0;
          if (vec_len != '0) begin
            cnt_d   = vec_len;
            state_d = ACC;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = '0;
          end
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d = acc_sat;
          cnt_d = cnt_q - LEN_W'(1);
          if (sat_hit) sat_flag_d = 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = acc_sat;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_bmac_accumulator.sv
// tb/tb_bmac_accumulator.sv - self-checking bench for bmac_accumulator
// Integer-level reference model checked every cycle, plus literal expectations per scenario.
module tb_bmac_accumulator;

  localparam int IN_W  = 16;
  localparam int ACC_W = 8;
  localparam int LEN_W = 8;
  localparam int MAXV  = (1 << (ACC_W-1)) - 1;
  localparam int MINV  = -(1 << (ACC_W-1));

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] vec_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic             busy;
  logic             sat_flag;

  int checks = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  // Reference model: phase 0=waiting for start, 1=collecting, 2=result held.
  int m_phase = 0;
  int m_sum   = 0;
  int m_left  = 0;
  int m_out   = 0;
  bit m_sat   = 1'b0;

  bmac_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .sat_flag(sat_flag)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      m_phase = 0; m_sum = 0; m_left = 0; m_out = 0; m_sat = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_sum = 0; m_sat = 1'b0;
          if (vec_len == 0) begin m_phase = 2; m_out = 0; end
          else begin m_phase = 1; m_left = int'(vec_len); end
        end
        1: if (in_valid) begin
          m_sum = m_sum + int'($signed(in_data));
          if (m_sum > MAXV) begin m_sum = MAXV; m_sat = 1'b1; end
          if (m_sum < MINV) begin m_sum = MINV; m_sat = 1'b1; end
          m_left = m_left - 1;
          if (m_left == 0) begin m_phase = 2; m_out = m_sum; end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("in_ready", {31'd0, in_ready}, (m_phase == 1) ? 1 : 0);
      chk("busy", {31'd0, busy}, (m_phase != 0) ? 1 : 0);
      chk("out_valid", {31'd0, out_valid}, (m_phase == 2) ? 1 : 0);
      chk("sat_flag", {31'd0, sat_flag}, {31'd0, m_sat});
      if (m_phase == 2) chk("out_data", 32'($signed(out_data)), m_out);
    end
  end

  task automatic do_start(input int n);
    start = 1'b1; vec_len = LEN_W'(n);
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic beat(input int v, input int gap);
    in_valid = 1'b1; in_data = IN_W'(v);
    @(negedge sys_clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic wait_out(input string name, input int exp, input int exp_sat, input bit release_it);
    int n = 0;
    while (!out_valid && n < 100) begin @(negedge sys_clk); n++; end
    chk({name, "_timeout"}, (n < 100) ? 1 : 0, 1);
    chk({name, "_data"}, 32'($signed(out_data)), exp);
    chk({name, "_sat"}, {31'd0, sat_flag}, exp_sat);
    if (release_it) begin
      out_ready = 1'b1;
      @(negedge sys_clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(negedge sys_clk);
    chk_en = 1'b1;
    chk("rst_out_data", 32'($signed(out_data)), 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Basic sum: -8+6+0+2 = 0
    do_start(4);
    beat(-8, 0); beat(6, 0); beat(0, 0); beat(2, 0);
    chk("basic_latency", {31'd0, out_valid}, 1);
    wait_out("basic", 0, 0, 1);

    // Stalls: 6+6-2 = 10 with 2-cycle gaps
    do_start(3);
    beat(6, 2); beat(6, 2);
    chk("stall_in_ready", {31'd0, in_ready}, 1);
    beat(-2, 0);
    wait_out("stall", 10, 0, 0);
    out_ready = 1'b1; @(negedge sys_clk); out_ready = 1'b0;

    // Backpressure with start pulses ignored
    do_start(2);
    beat(4, 0); beat(4, 0);
    for (int i = 0; i < 5; i++) begin
      start = i[0]; vec_len = 8'd3;
      @(negedge sys_clk);
      chk("bp_data", 32'($signed(out_data)), 8);
      chk("bp_busy", {31'd0, busy}, 1);
    end
    start = 1'b0;
    out_ready = 1'b1; @(negedge sys_clk); out_ready = 1'b0;
    chk("bp_idle_busy", {31'd0, busy}, 0);

    // Saturation high, low, then clear
    do_start(30);
    for (int i = 0; i < 30; i++) beat(6, 0);
    wait_out("sat_hi", 127, 1, 1);
    do_start(30);
    for (int i = 0; i < 30; i++) beat(-8, 0);
    wait_out("sat_lo", -128, 1, 1);
    do_start(1);
    beat(2, 0);
    wait_out("sat_clr", 2, 0, 1);

    // Zero length
    do_start(0);
    chk("zero_valid", {31'd0, out_valid}, 1);
    chk("zero_in_ready", {31'd0, in_ready}, 0);
    wait_out("zero", 0, 0, 1);

    // Reset mid-operation
    do_start(5);
    beat(3, 0); beat(3, 0); beat(3, 0);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_data", 32'($signed(out_data)), 0);
    do_start(1);
    beat(-4, 0);
    wait_out("after_rst", -4, 0, 1);

    repeat (2) @(negedge sys_clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
